pe_align_add: RTL and testbench
===============================

Name: pe_align_add

Overview:
- Downstream neighbour of the exponent-compare stage in the multi-precision PE.
- Consumes per-lane significand products plus the max exponent and per-lane exponent differences.
- Right-aligns each lane to the max exponent, converts it to two's complement, and sums all lanes through a 3-stage valid/ready pipeline.
- Emits an unnormalised signed sum, the exponent and a sticky bit to the normaliser/rounder.

Parameters:
- PW, 48: per-lane product width. Products are MSB-aligned; bit PW-1 has weight 2^1.
- GUARD, 3: extra low-order bits kept after alignment.
- SUM_W, PW+GUARD+5 (56): signed sum width. Covers sign plus 10-lane growth.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- mode  in  2  00 FP16 ×10 lanes; 01 FP32 ×5 lanes; 10/11 FP64 single lane
- max_exp  in  10  max product exponent, FP16/FP32 modes
- exp64  in  11  FP64 product exponent
- diff_0..diff_9  in  10 each  max_exp minus lane exponent, unsigned
- prod_0..prod_9  in  PW each  lane product magnitude
- sign_0..sign_9  in  1 each  lane product sign
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  SUM_W  signed aligned sum, two's complement
- out_exp  out  11  result exponent before normalisation
- out_sticky  out  1  OR of all bits shifted out of any lane
- out_mode  out  2  mode carried with the result

Behaviour:
- Single clock clk. Reset is synchronous and active-low on rst_n.
- Reset clears all stage valids, out_sum, out_exp, out_sticky and out_mode to 0. in_ready is 1 after reset.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. Every stage register advances only when en=1, so all three stages stall together.
- A beat is accepted when in_valid && in_ready. Latency is exactly 3 cycles with no stalls. Throughput is 1 beat/cycle.
- Bubbles propagate as valid=0, and their data registers still advance.
- Reset asserted mid-stream drops every in-flight beat. out_valid=0 on the next edge.
- Lane mask:
  - mode 00: lanes 0–9 active.
  - mode 01: lanes 0–4 active; lanes 5–9 are forced to zero and contribute nothing to sticky.
  - mode 1x: lane 0 only, with diff treated as 0; lanes 1–9 forced to zero.
- Stage 1 (align), per active lane:
  - Extend the product to PW+GUARD bits as {prod, GUARD zeros}.
  - Logical right shift by d = diff.
  - Lane sticky = OR of the bits shifted out. If d ≥ PW+GUARD, the lane becomes 0 and lane sticky = |prod.
  - If sign=1, negate to two's complement; result is sign-extended to SUM_W.
  - Register the 10 aligned lanes, the OR of all lane stickies, mode and exponent.
- Exponent:
  - mode 1x: {exp64}.
  - otherwise: {1'b0, max_exp}.
- Stage 2: register partial sums P0 = lanes 0–4 and P1 = lanes 5–9, both SUM_W wide.
- Stage 3: register out_sum = P0+P1. No overflow is possible by sizing. Pass sticky, exp and mode through.
- A zero product on a lane with sign=1 yields 0, never negative zero.
- out_* hold stable while out_valid && !out_ready.

Decomposition:
- Shared package pe_pkg:
  - mode encodings MODE_FP16=2'b00, MODE_FP32=2'b01, MODE_FP64=2'b10.
  - PW, GUARD, SUM_W, LANES=10.
- One natural sub-module, lane_align_shift: one lane of shift, sticky and conditional negate.
  - Inputs: prod, sign, diff, active.
  - Outputs: aligned SUM_W value and sticky.
  - Instantiated 10 times in stage 1.

Test Plan:
- Single beat, mode 00:
  - Stimulus: all prods = 48'h4000_0000_0000, all sign=0, all diff=0, max_exp=10'd20.
  - Response: 3 cycles later out_sum = 10×(48'h4000_0000_0000<<3), out_exp=11'd20, out_sticky=0.
- Alignment and sticky, mode 00:
  - Stimulus: lane0 prod=48'h8000_0000_0001, diff_0=4; other lanes prod=0.
  - Response: out_sum = (48'h8000_0000_0001<<3)>>4, out_sticky=1.
- Cancellation and oversized shift, mode 01:
  - Stimulus: lane0 = +P and lane1 = −P with P = 48'h1234_5678_9ABC, diff=0; lane2 diff=10'd60.
  - Response: out_sum=0. out_sticky=1 if lane2 prod≠0.
  - Also: lanes 5–9 driven nonzero must be ignored.
- FP64 mode:
  - Stimulus: mode=10, exp64=11'd1030, prod_0=48'hFFFF_FFFF_FFFF, sign_0=1, diff_0=7.
  - Response: out_sum = −(prod_0<<3), meaning the diff is ignored; out_exp=1030.
- Back-pressure:
  - Stimulus: stream 5 beats, hold out_ready=0 for 4 cycles after the first out_valid.
  - Response: in_ready=0 while stalled; out_* stable; all 5 results arrive in order, none lost or duplicated.
- Reset mid-stream:
  - Stimulus: 2 beats in flight, pull rst_n=0 for 1 cycle.
  - Response: out_valid=0 and out_sum=0 next cycle; no stale result appears afterwards.

Source files
------------

// File: rtl/pe_align_add_pkg.sv
// Shared constants and types for the PE alignment/accumulate stage.
package pe_pkg;

  localparam int PW     = 48;            // lane product width, MSB weight 2^1
  localparam int GUARD  = 3;             // low-order guard bits kept after shift
  localparam int EXT_W  = PW + GUARD;    // extended lane width before shifting
  localparam int SUM_W  = PW + GUARD + 5; // sign + growth for 10 lanes
  localparam int LANES  = 10;
  localparam int DIFF_W = 10;
  localparam int EXP_W  = 11;
  localparam int STAGES = 3;

  localparam logic [1:0] MODE_FP16 = 2'b00;
  localparam logic [1:0] MODE_FP32 = 2'b01;
  localparam logic [1:0] MODE_FP64 = 2'b10;

  // Side-band carried alongside the datapath through every stage
  typedef struct packed {
    logic             sticky;
    logic [1:0]       mode;
    logic [EXP_W-1:0] exp;
  } meta_t;

  // Which lanes carry data in a given mode; mode 1x uses lane 0 only
  function automatic logic lane_active(input logic [1:0] mode, input int lane);
    if (mode[1])               return (lane == 0);
    else if (mode == MODE_FP32) return (lane < 5);
    else                        return 1'b1;
  endfunction

endpackage

// File: rtl/pe_align_add_lane.sv
// One lane: right-align the extended product, collect shifted-out bits,
// and convert the magnitude to a sign-extended two's complement value.
module lane_align_shift
  import pe_pkg::*;
(
  input  logic [PW-1:0]     prod,
  input  logic              sign,
  input  logic [DIFF_W-1:0] diff,
  input  logic              active,
  output logic [SUM_W-1:0]  aligned,
  output logic              sticky
);

  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] mag;
  logic [EXT_W-1:0] lost_mask;
  logic [SUM_W-1:0] mag_ext;

  // Shift, sticky and conditional negate; inactive lanes contribute nothing
  always_comb begin
    ext       = {prod, {GUARD{1'b0}}};
    mag       = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    if (active) begin
      if (diff >= DIFF_W'(EXT_W)) begin
        // Whole lane shifted out; only the product bits can be nonzero
        sticky = |prod;
      end else begin
        mag       = ext >> diff;
        lost_mask = ~({EXT_W{1'b1}} << diff);
        sticky    = |(ext & lost_mask);
      end
    end
    mag_ext = {{(SUM_W-EXT_W){1'b0}}, mag};
    // Negating zero yields zero, so no negative-zero special case is needed
    aligned = sign ? (~mag_ext + SUM_W'(1)) : mag_ext;
  end

endmodule

// File: rtl/pe_align_add.sv
// Align all lanes to the max exponent and sum them through a 3-stage
// valid/ready pipeline that stalls as a single unit.
module pe_align_add
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [9:0]        max_exp,
  input  logic [10:0]       exp64,
  input  logic [DIFF_W-1:0] diff_0, diff_1, diff_2, diff_3, diff_4,
  input  logic [DIFF_W-1:0] diff_5, diff_6, diff_7, diff_8, diff_9,
  input  logic [PW-1:0]     prod_0, prod_1, prod_2, prod_3, prod_4,
  input  logic [PW-1:0]     prod_5, prod_6, prod_7, prod_8, prod_9,
  input  logic              sign_0, sign_1, sign_2, sign_3, sign_4,
  input  logic              sign_5, sign_6, sign_7, sign_8, sign_9,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [10:0]       out_exp,
  output logic              out_sticky,
  output logic [1:0]        out_mode
);

  logic [LANES-1:0][PW-1:0]     prod_a;
  logic [LANES-1:0][DIFF_W-1:0] diff_a;
  logic [LANES-1:0]             sign_a;
  logic [LANES-1:0][SUM_W-1:0]  lane_aligned;
  logic [LANES-1:0]             lane_sticky;

  assign prod_a = {prod_9, prod_8, prod_7, prod_6, prod_5,
                   prod_4, prod_3, prod_2, prod_1, prod_0};
  assign diff_a = {diff_9, diff_8, diff_7, diff_6, diff_5,
                   diff_4, diff_3, diff_2, diff_1, diff_0};
  assign sign_a = {sign_9, sign_8, sign_7, sign_6, sign_5,
                   sign_4, sign_3, sign_2, sign_1, sign_0};

  // Per-lane alignment; FP64 ignores diff since there is a single product
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DIFF_W-1:0] eff_diff;
    logic              act;
    assign eff_diff = mode[1] ? '0 : diff_a[g];
    assign act      = lane_active(mode, g);

    lane_align_shift u_lane (
      .prod    (prod_a[g]),
      .sign    (sign_a[g]),
      .diff    (eff_diff),
      .active  (act),
      .aligned (lane_aligned[g]),
      .sticky  (lane_sticky[g])
    );
  end

  logic                        en;
  logic [STAGES:1]             vld_pipe_q, vld_pipe_d;
  logic [LANES-1:0][SUM_W-1:0] lane_q, lane_d;
  meta_t                       meta1_q, meta1_d;
  meta_t                       meta2_q, meta2_d;
  meta_t                       meta3_q, meta3_d;
  logic [SUM_W-1:0]            p0_q, p0_d, p1_q, p1_d;
  logic [SUM_W-1:0]            sum_q, sum_d;
  logic [SUM_W-1:0]            p0_acc, p1_acc;
  meta_t                       meta_in;

  // A full output register with no taker freezes the whole pipe
  assign en       = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready = en;

  // Next-state for all stages; registers hold unless the pipe advances
  always_comb begin
    meta_in.sticky = |lane_sticky;
    meta_in.mode   = mode;
    meta_in.exp    = mode[1] ? exp64 : {1'b0, max_exp};

    p0_acc = '0;
    p1_acc = '0;
    for (int i = 0; i < 5; i++) begin
      p0_acc = p0_acc + lane_q[i];
      p1_acc = p1_acc + lane_q[i+5];
    end

    vld_pipe_d = vld_pipe_q;
    lane_d     = lane_q;
    meta1_d    = meta1_q;
    meta2_d    = meta2_q;
    meta3_d    = meta3_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    sum_d      = sum_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
      lane_d     = lane_aligned;
      meta1_d    = meta_in;
      p0_d       = p0_acc;
      p1_d       = p1_acc;
      meta2_d    = meta1_q;
      sum_d      = p0_q + p1_q;
      meta3_d    = meta2_q;
    end
  end

  // Pipeline registers with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      lane_q     <= '0;
      meta1_q    <= '0;
      meta2_q    <= '0;
      meta3_q    <= '0;
      p0_q       <= '0;
      p1_q       <= '0;
      sum_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      lane_q     <= lane_d;
      meta1_q    <= meta1_d;
      meta2_q    <= meta2_d;
      meta3_q    <= meta3_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      sum_q      <= sum_d;
    end
  end

  assign out_valid  = vld_pipe_q[STAGES];
  assign out_sum    = sum_q;
  assign out_exp    = meta3_q.exp;
  assign out_sticky = meta3_q.sticky;
  assign out_mode   = meta3_q.mode;

endmodule

// File: tb/tb_pe_align_add.sv
// Directed bench for pe_align_add: vector table plus stall and reset sequences.
module tb_pe_align_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  mode, out_mode;
  logic [9:0]  max_exp;
  logic [10:0] exp64, out_exp;
  logic [9:0]  diff [10];
  logic [47:0] prod [10];
  logic        sign [10];
  logic [55:0] out_sum;
  logic        out_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pe_align_add dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .max_exp(max_exp), .exp64(exp64),
    .diff_0(diff[0]), .diff_1(diff[1]), .diff_2(diff[2]), .diff_3(diff[3]), .diff_4(diff[4]),
    .diff_5(diff[5]), .diff_6(diff[6]), .diff_7(diff[7]), .diff_8(diff[8]), .diff_9(diff[9]),
    .prod_0(prod[0]), .prod_1(prod[1]), .prod_2(prod[2]), .prod_3(prod[3]), .prod_4(prod[4]),
    .prod_5(prod[5]), .prod_6(prod[6]), .prod_7(prod[7]), .prod_8(prod[8]), .prod_9(prod[9]),
    .sign_0(sign[0]), .sign_1(sign[1]), .sign_2(sign[2]), .sign_3(sign[3]), .sign_4(sign[4]),
    .sign_5(sign[5]), .sign_6(sign[6]), .sign_7(sign[7]), .sign_8(sign[8]), .sign_9(sign[9]),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_exp(out_exp), .out_sticky(out_sticky), .out_mode(out_mode)
  );

  typedef struct {
    logic [1:0]       mode;
    logic [9:0]       max_exp;
    logic [10:0]      exp64;
    logic [9:0][9:0]  diff;
    logic [9:0][47:0] prod;
    logic [9:0]       sign;
    logic [55:0]      e_sum;
    logic [10:0]      e_exp;
    logic             e_sticky;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0;
    mode     = 2'b00;
    max_exp  = '0;
    exp64    = '0;
    for (int i = 0; i < 10; i++) begin
      diff[i] = '0; prod[i] = '0; sign[i] = 1'b0;
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int cnt;
    mode    = v.mode;
    max_exp = v.max_exp;
    exp64   = v.exp64;
    for (int i = 0; i < 10; i++) begin
      diff[i] = v.diff[i]; prod[i] = v.prod[i]; sign[i] = v.sign[i];
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check($sformatf("v%0d_latency", idx), 64'(cnt + 1), 64'd3);
    check($sformatf("v%0d_sum", idx),    64'(out_sum),    64'(v.e_sum));
    check($sformatf("v%0d_exp", idx),    64'(out_exp),    64'(v.e_exp));
    check($sformatf("v%0d_sticky", idx), 64'(out_sticky), 64'(v.e_sticky));
    check($sformatf("v%0d_mode", idx),   64'(out_mode),   64'(v.mode));
  endtask

  initial begin
    logic [55:0] tmp;
    logic [55:0] snap_sum;
    logic [10:0] snap_exp;
    int          got_n, extra, guard;

    // ---- vector table ----
    for (int i = 0; i < NV; i++) vt[i] = '{default: '0};
    // 0: ten equal lanes, no shift
    vt[0].mode = 2'b00; vt[0].max_exp = 10'd20;
    for (int i = 0; i < 10; i++) vt[0].prod[i] = 48'h4000_0000_0000;
    vt[0].e_sum = 56'h14_0000_0000_0000; vt[0].e_exp = 11'd20; vt[0].e_sticky = 1'b0;
    // 1: shift by 4 drops a set guard bit
    vt[1].mode = 2'b00; vt[1].max_exp = 10'd5;
    vt[1].prod[0] = 48'h8000_0000_0001; vt[1].diff[0] = 10'd4;
    vt[1].e_sum = 56'h0000_4000_0000_0000; vt[1].e_exp = 11'd5; vt[1].e_sticky = 1'b1;
    // 2: FP32 cancellation, oversized shift, masked upper lanes
    vt[2].mode = 2'b01; vt[2].max_exp = 10'd7;
    vt[2].prod[0] = 48'h1234_5678_9ABC;
    vt[2].prod[1] = 48'h1234_5678_9ABC; vt[2].sign[1] = 1'b1;
    vt[2].prod[2] = 48'h0000_0000_0001; vt[2].diff[2] = 10'd60;
    for (int i = 5; i < 10; i++) vt[2].prod[i] = 48'hFFFF_0000_1234;
    vt[2].e_sum = '0; vt[2].e_exp = 11'd7; vt[2].e_sticky = 1'b1;
    // 3: FP32 masked lanes must not set sticky
    vt[3].mode = 2'b01; vt[3].max_exp = 10'd1000;
    vt[3].prod[3] = 48'h10;
    vt[3].prod[4] = 48'h2; vt[3].diff[4] = 10'd1;
    for (int i = 5; i < 10; i++) begin
      vt[3].prod[i] = 48'hFFFF_FFFF_FFFF; vt[3].diff[i] = 10'd60; vt[3].sign[i] = 1'b1;
    end
    vt[3].e_sum = 56'h88; vt[3].e_exp = 11'd1000; vt[3].e_sticky = 1'b0;
    // 4: FP64 ignores diff and lanes 1-9
    vt[4].mode = 2'b10; vt[4].max_exp = 10'd3; vt[4].exp64 = 11'd1030;
    vt[4].prod[0] = 48'hFFFF_FFFF_FFFF; vt[4].sign[0] = 1'b1; vt[4].diff[0] = 10'd7;
    for (int i = 1; i < 10; i++) begin vt[4].prod[i] = 48'h1; vt[4].diff[i] = 10'd60; end
    tmp = 56'h7_FFFF_FFFF_FFF8;
    vt[4].e_sum = -tmp; vt[4].e_exp = 11'd1030; vt[4].e_sticky = 1'b0;
    // 5: negative zero, shift == PW+GUARD, shift == PW+GUARD-1
    vt[5].mode = 2'b00; vt[5].max_exp = 10'd1023;
    vt[5].sign[0] = 1'b1;
    vt[5].prod[1] = 48'h1; vt[5].diff[1] = 10'd51;
    vt[5].prod[2] = 48'h8000_0000_0000; vt[5].diff[2] = 10'd50;
    vt[5].e_sum = 56'h1; vt[5].e_exp = 11'd1023; vt[5].e_sticky = 1'b1;
    // 6: mode 11 behaves as FP64
    vt[6].mode = 2'b11; vt[6].exp64 = 11'd2047; vt[6].max_exp = 10'd9;
    vt[6].prod[0] = 48'h1; vt[6].diff[0] = 10'd1023;
    vt[6].e_sum = 56'h8; vt[6].e_exp = 11'd2047; vt[6].e_sticky = 1'b0;

    // ---- reset state ----
    clear_inputs();
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_sum",    64'(out_sum),    64'd0);
    check("rst_out_exp",    64'(out_exp),    64'd0);
    check("rst_out_sticky", 64'(out_sticky), 64'd0);
    check("rst_out_mode",   64'(out_mode),   64'd0);
    check("rst_in_ready",   64'(in_ready),   64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) apply_vec(vt[v], v);
    clear_inputs();
    repeat (4) @(posedge clk);
    #1;

    // ---- back-pressure: 5 beats, 4-cycle stall on first result ----
    got_n = 0;
    fork
      begin : drv
        for (int k = 0; k < 5; k++) begin
          clear_inputs();
          prod[0]  = 48'(k + 1);
          max_exp  = 10'(k + 1);
          in_valid = 1'b1;
          guard = 0;
          do begin
            @(negedge clk);
            guard++;
          end while (!in_ready && guard < 50);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : stall
        int w;
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        check("bp_first_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        snap_sum  = out_sum;
        snap_exp  = out_exp;
        for (int s = 0; s < 4; s++) begin
          @(posedge clk); #1;
          check("bp_in_ready_low", 64'(in_ready),  64'd0);
          check("bp_hold_valid",   64'(out_valid), 64'd1);
          check("bp_hold_sum",     64'(out_sum),   64'(snap_sum));
          check("bp_hold_exp",     64'(out_exp),   64'(snap_exp));
        end
        out_ready = 1'b1;
      end
      begin : mon
        for (int c = 0; c < 60 && got_n < 5; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            check($sformatf("bp_sum%0d", got_n), 64'(out_sum), 64'(56'(got_n + 1) << 3));
            check($sformatf("bp_exp%0d", got_n), 64'(out_exp), 64'(got_n + 1));
            got_n++;
          end
        end
      end
    join
    check("bp_count", 64'(got_n), 64'd5);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("bp_no_dup", 64'(extra), 64'd0);
    @(posedge clk); #1;

    // ---- reset mid-stream ----
    clear_inputs();
    out_ready = 1'b1;
    prod[0] = 48'h5; max_exp = 10'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    prod[0] = 48'h6; max_exp = 10'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum",   64'(out_sum),   64'd0);
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("mid_rst_no_stale", 64'(extra), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
